ram_1wrs_ext: RTL and testbench

RAM_1WRS_EXT -- requirements
Module: ram_1wrs_ext

---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_1wrs_lane.sv | 35 +++
 rtl/ram_1wrs_ext.sv | 105 ++++++++++
 tb/tb_ram_1wrs_ext.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the single-port masked RAM: read-under-write mode names,
// clear-engine state encoding and the lane-width helper.
package ram_pkg;

  localparam string RUW_WRITE_FIRST = "writeFirst";
  localparam string RUW_READ_FIRST  = "readFirst";
  localparam string RUW_DONT_CARE   = "dontCare";

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } clr_state_e;

  function automatic int lane_width(input int word_width, input int mask_width);
    return word_width / mask_width;
  endfunction

endpackage

// File: rtl/ram_1wrs_lane.sv
// One write-mask lane of storage with a registered read port.
// Holds a slice of every word so masked writes become plain per-lane writes.
module ram_1wrs_lane #(
  parameter int depth       = 2048,
  parameter int width       = 8,
  parameter bit write_first = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(depth)-1:0] addr,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata
);

  logic [width-1:0] mem [depth];

  // NOTE: the array has no reset; zeroing is done by ordinary writes from the
  // clear engine so the storage still maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // NOTE: with non-blocking assignment, mem[addr] here is the pre-write word,
  // which is exactly the readFirst behaviour; writeFirst forwards wdata instead.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (write_first && we) ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/ram_1wrs_ext.sv
// Single-port RAM with per-lane write mask, selectable read-under-write mode,
// optional output register and a zero-fill engine that runs after reset.
module ram_1wrs_ext
  import ram_pkg::*;
#(
  parameter int    wordCount      = 2048,
  parameter int    wordWidth      = 32,
  parameter int    maskWidth      = 4,
  parameter string readUnderWrite = RUW_WRITE_FIRST,
  parameter int    outputReg      = 0,
  parameter int    clearOnReset   = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         en,
  input  logic                         wr,
  input  logic [$clog2(wordCount)-1:0] addr,
  input  logic [maskWidth-1:0]         mask,
  input  logic [wordWidth-1:0]         wrData,
  output logic [wordWidth-1:0]         rdData,
  output logic                         rdValid,
  output logic                         busy
);

  localparam int            AW          = $clog2(wordCount);
  localparam int            LW          = lane_width(wordWidth, maskWidth);
  localparam bit            WRITE_FIRST = (readUnderWrite == RUW_WRITE_FIRST);
  localparam bit            DO_CLEAR    = (clearOnReset != 0);
  localparam logic [AW:0]   LAST_ADDR   = (AW + 1)'(wordCount - 1);

  clr_state_e           state;
  logic [AW:0]          clr_cnt;
  logic                 clearing;
  logic                 acc;
  logic                 rd_v1;
  logic [AW-1:0]        mem_addr;
  logic [wordWidth-1:0] q1;

  // busy is registered with the state, so CLEAR and accepted accesses never overlap.
  assign acc      = resetn & en & ~busy;
  assign clearing = resetn & (state == ST_CLEAR);
  assign mem_addr = clearing ? clr_cnt[AW-1:0] : addr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= DO_CLEAR ? ST_CLEAR : ST_READY;
      busy    <= DO_CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= DO_CLEAR ? ST_CLEAR : ST_READY;
          busy    <= DO_CLEAR;
          clr_cnt <= '0;
        end
        ST_CLEAR: begin
          // Counter parks at wordCount instead of wrapping back to address 0.
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

  for (genvar i = 0; i < maskWidth; i++) begin : g_lane
    ram_1wrs_lane #(
      .depth       (wordCount),
      .width       (LW),
      .write_first (WRITE_FIRST)
    ) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .we     (clearing | (acc & wr & mask[i])),
      .re     (acc),
      .addr   (mem_addr),
      .wdata  (clearing ? '0 : wrData[i*LW +: LW]),
      .rdata  (q1[i*LW +: LW])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) rd_v1 <= 1'b0;
    else         rd_v1 <= acc;
  end

  if (outputReg != 0) begin : g_oreg
    always_ff @(posedge clk) begin
      if (!resetn) begin
        rdData  <= '0;
        rdValid <= 1'b0;
      end else begin
        rdValid <= rd_v1;
        if (rd_v1) rdData <= q1;
      end
    end
  end else begin : g_noreg
    assign rdData  = q1;
    assign rdValid = rd_v1;
  end

endmodule

// File: tb/tb_ram_1wrs_ext.sv
// Directed bench for ram_1wrs_ext: four instances (writeFirst, readFirst,
// output-registered, no-clear) share one stimulus bus and are checked against fixed vectors.
module tb_ram_1wrs_ext;

  localparam int WC = 16;
  localparam int WW = 32;
  localparam int MW = 4;
  localparam int AW = 4;

  logic          clk;
  logic          resetn;
  logic          en;
  logic          wr;
  logic [AW-1:0] addr;
  logic [MW-1:0] mask;
  logic [WW-1:0] wr_data;

  logic [WW-1:0] rd_wf, rd_rf, rd_or, rd_nc;
  logic          v_wf, v_rf, v_or, v_nc;
  logic          b_wf, b_rf, b_or, b_nc;

  int n_checks;
  int n_fail;

  ram_1wrs_ext #(.wordCount(WC), .wordWidth(WW), .maskWidth(MW), .readUnderWrite("writeFirst"),
                 .outputReg(0), .clearOnReset(1)) u_wf (
    .clk(clk), .resetn(resetn), .en(en), .wr(wr), .addr(addr), .mask(mask), .wrData(wr_data),
    .rdData(rd_wf), .rdValid(v_wf), .busy(b_wf));

  ram_1wrs_ext #(.wordCount(WC), .wordWidth(WW), .maskWidth(MW), .readUnderWrite("readFirst"),
                 .outputReg(0), .clearOnReset(1)) u_rf (
    .clk(clk), .resetn(resetn), .en(en), .wr(wr), .addr(addr), .mask(mask), .wrData(wr_data),
    .rdData(rd_rf), .rdValid(v_rf), .busy(b_rf));

  ram_1wrs_ext #(.wordCount(WC), .wordWidth(WW), .maskWidth(MW), .readUnderWrite("writeFirst"),
                 .outputReg(1), .clearOnReset(1)) u_or (
    .clk(clk), .resetn(resetn), .en(en), .wr(wr), .addr(addr), .mask(mask), .wrData(wr_data),
    .rdData(rd_or), .rdValid(v_or), .busy(b_or));

  ram_1wrs_ext #(.wordCount(WC), .wordWidth(WW), .maskWidth(MW), .readUnderWrite("writeFirst"),
                 .outputReg(0), .clearOnReset(0)) u_nc (
    .clk(clk), .resetn(resetn), .en(en), .wr(wr), .addr(addr), .mask(mask), .wrData(wr_data),
    .rdData(rd_nc), .rdValid(v_nc), .busy(b_nc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one access and advance to the next sampling point.
  task automatic op(input logic w, input int a, input logic [MW-1:0] m, input logic [WW-1:0] d);
    en      = 1'b1;
    wr      = w;
    addr    = a[AW-1:0];
    mask    = m;
    wr_data = d;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    en = 1'b0;
    wr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int            n;
    logic          any_v;
    logic          exp_v [5];
    logic [WW-1:0] exp_d [5];

    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    en       = 1'b0;
    wr       = 1'b0;
    addr     = '0;
    mask     = '0;
    wr_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rddata_wf", rd_wf, 32'h0);
    check("rst_rdvalid_wf", v_wf, 1'b0);
    check("rst_busy_wf", b_wf, 1'b1);
    check("rst_busy_nc", b_nc, 1'b0);

    // Clear runs for exactly wordCount cycles after reset release
    resetn = 1'b1;
    n = 0;
    while (b_wf && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("clear_len", n, WC);

    for (int i = 0; i < WC; i++) begin
      op(1'b0, i, 4'h0, 32'h0);
      check($sformatf("clr_rd%0d", i), rd_wf, 32'h0);
      check($sformatf("clr_vld%0d", i), v_wf, 1'b1);
    end

    // Masked merge, then back-to-back read of the just-written address
    op(1'b1, 5, 4'hF, 32'hAABBCCDD);
    check("wr5_ret_wf", rd_wf, 32'hAABBCCDD);
    op(1'b1, 5, 4'h5, 32'h11223344);
    check("merge_ret_wf", rd_wf, 32'hAA22CC44);
    check("merge_ret_rf", rd_rf, 32'hAABBCCDD);
    op(1'b0, 5, 4'h0, 32'h0);
    check("merge_rd_wf", rd_wf, 32'hAA22CC44);
    check("merge_rd_vld", v_wf, 1'b1);

    // Read-under-write modes
    op(1'b1, 3, 4'hF, 32'h12345678);
    op(1'b1, 3, 4'h3, 32'hFFFFFFFF);
    check("ruw_wf", rd_wf, 32'h1234FFFF);
    check("ruw_rf", rd_rf, 32'h12345678);
    check("ruw_vld_wf", v_wf, 1'b1);
    check("ruw_vld_rf", v_rf, 1'b1);
    op(1'b0, 3, 4'h0, 32'h0);
    check("ruw_rd_rf", rd_rf, 32'h1234FFFF);
    idle_cycle();
    check("idle_vld_wf", v_wf, 1'b0);
    check("idle_hold_wf", rd_wf, 32'h1234FFFF);

    // Output register: reads every cycle of addr 0,1,2 holding 7,8,9
    op(1'b1, 0, 4'hF, 32'd7);
    op(1'b1, 1, 4'hF, 32'd8);
    op(1'b1, 2, 4'hF, 32'd9);
    idle_cycle();
    idle_cycle();
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d = '{32'd9, 32'd7, 32'd8, 32'd9, 32'd9};
    for (int k = 0; k < 5; k++) begin
      if (k < 3) op(1'b0, k, 4'h0, 32'h0);
      else       idle_cycle();
      check($sformatf("oreg_vld%0d", k), v_or, exp_v[k]);
      check($sformatf("oreg_data%0d", k), rd_or, exp_d[k]);
    end

    // Reset in the middle of a clear restarts it; writes during busy are dropped
    resetn = 1'b0;
    @(negedge clk);
    check("rst2_rddata_wf", rd_wf, 32'h0);
    resetn = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_busy", b_wf, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_vld", v_wf, 1'b0);
    check("midrst_busy", b_wf, 1'b1);
    resetn  = 1'b1;
    en      = 1'b1;
    wr      = 1'b1;
    addr    = 4'd2;
    mask    = 4'hF;
    wr_data = 32'hDEADBEEF;
    n       = 0;
    any_v   = 1'b0;
    while (b_wf && n < 100) begin
      @(negedge clk);
      n++;
      if (v_wf) any_v = 1'b1;
    end
    en = 1'b0;
    check("restart_len", n, WC);
    check("busy_no_vld", any_v, 1'b0);
    op(1'b0, 2, 4'h0, 32'h0);
    check("busy_wr_dropped", rd_wf, 32'h0);

    // No-clear instance keeps its contents across reset
    op(1'b1, 1, 4'hF, 32'h0000005A);
    check("nc_wr_ret", rd_nc, 32'h0000005A);
    en     = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("nc_rst_rddata", rd_nc, 32'h0);
    check("nc_rst_busy", b_nc, 1'b0);
    resetn = 1'b1;
    op(1'b0, 1, 4'h0, 32'h0);
    check("nc_retained", rd_nc, 32'h0000005A);
    check("nc_retained_vld", v_nc, 1'b1);
    en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
